// File: rtl/crossbar_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_sched_pkg
// Brief    : Shared types and helpers for the crossbar route scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package crossbar_sched_pkg;

  localparam int C_CW_MAX          = 256;
  localparam int C_DEF_N_INPUTS    = 2;
  localparam int C_DEF_N_OUTPUTS   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_XFER = 2'd2
  } sched_state_t;

  // Select-field width; a single-port side still gets one bit of field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [C_CW_MAX-1:0] build_control(
    input int                    cw,
    input int                    n_in,
    input int                    n_out,
    input logic [C_CW_MAX-1:0]   in_sel,
    input logic [C_CW_MAX-1:0]   out_sel
  );
    int                  in_w;
    int                  out_w;
    logic [C_CW_MAX-1:0] word;
    in_w  = idx_width(n_in);
    out_w = idx_width(n_out);
    word  = (in_sel << (cw - in_w)) | (out_sel << (cw - in_w - out_w));
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crossbar_route_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of the first request at/after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import crossbar_sched_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    logic w_found;
    int   w_idx;
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (en && !w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = IDX_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/crossbar_route_sched.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_route_sched
// Brief    : Arbitrates route requests, programs the crossbar and holds each
//            route until its burst has fired on the destination output.
// Revision : 1.0 - initial release
// ============================================================================
module crossbar_route_sched
  import crossbar_sched_pkg::*;
#(
  parameter int N_INPUTS          = C_DEF_N_INPUTS,
  parameter int N_OUTPUTS         = C_DEF_N_OUTPUTS,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int LEN_W             = 8,
  parameter int TIMEOUT           = 0,
  localparam int IN_W             = idx_width(N_INPUTS),
  localparam int OUT_W            = idx_width(N_OUTPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_INPUTS-1:0]          req_val,
  output logic [N_INPUTS-1:0]          req_rdy,
  input  logic [N_INPUTS*OUT_W-1:0]    req_dest,
  input  logic [N_INPUTS*LEN_W-1:0]    req_len,
  output logic [CONTROL_BIT_WIDTH-1:0] control,
  output logic                         control_val,
  input  logic                         control_rdy,
  input  logic [N_OUTPUTS-1:0]         send_val,
  input  logic [N_OUTPUTS-1:0]         send_rdy,
  output logic                         busy,
  output logic                         route_done,
  output logic                         route_err
);

  sched_state_t       r_state;
  logic [IN_W-1:0]    r_ptr;
  logic [IN_W-1:0]    r_cur_in;
  logic [OUT_W-1:0]   r_cur_out;
  logic [LEN_W-1:0]   r_cnt_left;
  logic               r_control_val;
  logic               r_busy;
  logic               r_route_done;
  logic               r_route_err;

  logic [N_INPUTS-1:0] w_gnt;
  logic [IN_W-1:0]     w_gnt_idx;
  logic                w_any;
  logic [OUT_W-1:0]    w_dest_sel;
  logic [LEN_W-1:0]    w_len_sel;
  logic [IN_W-1:0]     w_ptr_next;
  logic                w_fire;
  logic                w_timeout;

  rr_arbiter #(
    .N     (N_INPUTS),
    .IDX_W (IN_W)
  ) u_arb (
    .req     (req_val),
    .ptr     (r_ptr),
    .en      (r_state == ST_IDLE),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_any      = |w_gnt;
  assign w_dest_sel = req_dest[w_gnt_idx*OUT_W +: OUT_W];
  assign w_len_sel  = req_len[w_gnt_idx*LEN_W +: LEN_W];
  assign w_ptr_next = (w_gnt_idx == IN_W'(N_INPUTS - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_fire     = send_val[r_cur_out] & send_rdy[r_cur_out];

  generate
    if (TIMEOUT > 0) begin : g_wd_on
      localparam int IDLE_W = $clog2(TIMEOUT + 1);
      logic [IDLE_W-1:0] r_idle_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_idle_cnt <= '0;
        end else if (r_state != ST_XFER || w_fire) begin
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end

      // A fire in the expiry cycle wins, so completion beats abort.
      assign w_timeout = (r_state == ST_XFER) && !w_fire &&
                         (r_idle_cnt == IDLE_W'(TIMEOUT - 1));
    end else begin : g_wd_off
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_cur_in      <= '0;
      r_cur_out     <= '0;
      r_cnt_left    <= '0;
      r_control_val <= 1'b0;
      r_busy        <= 1'b0;
      r_route_done  <= 1'b0;
      r_route_err   <= 1'b0;
    end else begin
      r_route_done <= 1'b0;
      r_route_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_cur_in      <= w_gnt_idx;
            r_cur_out     <= w_dest_sel;
            r_cnt_left    <= w_len_sel;
            r_ptr         <= w_ptr_next;
            r_control_val <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_CFG;
          end
        end
        ST_CFG: begin
          if (control_rdy) begin
            r_control_val <= 1'b0;
            if (r_cnt_left == '0) begin
              r_route_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_state <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (w_fire) begin
            r_cnt_left <= r_cnt_left - 1'b1;
            if (r_cnt_left == LEN_W'(1)) begin
              r_route_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_route_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_control_val <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  // The word is a pure function of the latched route, so it only changes on a grant.
  assign control     = CONTROL_BIT_WIDTH'(build_control(CONTROL_BIT_WIDTH, N_INPUTS, N_OUTPUTS,
                                                       C_CW_MAX'(r_cur_in), C_CW_MAX'(r_cur_out)));
  assign req_rdy     = w_gnt & {N_INPUTS{reset}};
  assign control_val = r_control_val;
  assign busy        = r_busy;
  assign route_done  = r_route_done;
  assign route_err   = r_route_err;

endmodule
`default_nettype wire

// File: doc/crossbar_route_sched.md
# crossbar_route_sched

Route scheduler for `crossbarVRTL`. It takes route requests (source input, destination output, burst length) from up to N_INPUTS requesters and round-robin-arbitrates among them. It programs the crossbar's control port for the winning route, holds that route until the requested number of transfers has fired on the destination output, then releases it. It sits beside the crossbar and owns its `control` / `control_val` / `control_rdy` interface exclusively.

## Interface
- N_INPUTS, 2: crossbar inputs, which is also the number of requesters (requester i always sources crossbar input i).
- N_OUTPUTS, 2: crossbar outputs.
- CONTROL_BIT_WIDTH, 42: width of the crossbar control word.
- LEN_W, 8: burst-length width.
- TIMEOUT, 0: maximum idle cycles between fires in XFER before the burst is aborted; 0 disables the watchdog.
- clk  in  1  single clock for the block.
- reset  in  1  asynchronous, active-low.
- req_val  in  N_INPUTS  per-requester route request valid.
- req_rdy  out  N_INPUTS  one-hot; high only for the requester granted this cycle.
- req_dest  in  N_INPUTS*log2(N_OUTPUTS)  requested output, requester 0 in the LSBs.
- req_len  in  N_INPUTS*LEN_W  burst length in transfers, requester 0 in the LSBs.
- control  out  CONTROL_BIT_WIDTH  crossbar control word.
- control_val  out  1  control word valid.
- control_rdy  in  1  crossbar accepts the control word.
- send_val  in  N_OUTPUTS  monitored crossbar output valids.
- send_rdy  in  N_OUTPUTS  monitored crossbar output readies.
- busy  out  1  a route is held (state is not IDLE).
- route_done  out  1  one-cycle pulse when a burst completes.
- route_err  out  1  one-cycle pulse when the watchdog aborts a burst.

## Operation
- Control word layout:
  - input_sel occupies [CW-1 -: log2(N_INPUTS)].
  - output_sel occupies the next log2(N_OUTPUTS) bits below it.
  - All remaining bits are 0.
- FSM states: IDLE, CFG, XFER.
- IDLE:
  - If any req_val is set, grant the first set bit at or after prio_ptr (circular search).
  - Pulse req_rdy for the granted requester in the same cycle.
  - Latch cur_in, cur_out = req_dest[cur_in], and cnt_left = req_len[cur_in].
  - Advance prio_ptr to (cur_in+1) mod N_INPUTS.
  - Go to CFG.
- CFG:
  - Drive control_val=1 with the latched word.
  - Stay in CFG while control_rdy=0.
  - On the handshake: if cnt_left=0, pulse route_done and go to IDLE; otherwise go to XFER.
- XFER:
  - A fire is send_val[cur_out] & send_rdy[cur_out]; each fire decrements cnt_left.
  - On the fire that brings cnt_left to 0, go to IDLE and pulse route_done on the following cycle.
- Watchdog (TIMEOUT>0):
  - idle_cnt resets on every fire and on entry to XFER.
  - When idle_cnt reaches TIMEOUT, go to IDLE and pulse route_err; route_done is not pulsed.
- Fires in IDLE or CFG are ignored and never counted.
- Requests are sampled only in IDLE; req_val changes at other times have no effect.
- When no request is pending in IDLE, the block issues no control write; the crossbar keeps its last route.
- The latched route is never rewritten while in CFG or XFER.

## Timing
- Reset values: state IDLE, prio_ptr 0, control 0, control_val 0, req_rdy 0, busy 0, route_done 0, route_err 0, counters 0.
- Reset mid-burst returns to IDLE immediately and asynchronously, and drops control_val. No done or err pulse is issued.
- Grant at cycle T (IDLE), then control_val at T+1. With control_rdy=1, the crossbar route is live from T+2.
- The first countable fire is at T+2. The minimum busy period for len L is L+1 cycles (CFG plus L fires).
- After the final fire at cycle F: IDLE at F+1, route_done at F+1, and the next grant is possible at F+1.
- control, cur_in and cur_out are registered and stable from CFG entry until IDLE.
- A final fire and a watchdog expiry in the same cycle count as completion: route_done, not route_err.

## Structure
- Package crossbar_sched_pkg holds:
  - the state enum (IDLE/CFG/XFER);
  - a function building the control word from input_sel and output_sel for a given CW, N_INPUTS and N_OUTPUTS;
  - log2 width constants.
- Sub-module rr_arbiter (N parameter): inputs req[N], ptr and en; outputs one-hot gnt and gnt_idx. It is purely combinational; prio_ptr lives in the parent.

## Test plan
- Single request, N_INPUTS=N_OUTPUTS=2, req 1, dest 0, len 3, send_rdy always high:
  - control bits [41:40] = 2'b10 at T+1;
  - exactly 3 fires are counted;
  - route_done at cycle F+1;
  - busy high for 4 cycles.
- req_val=2'b11 held continuously, len 1 each: grants alternate 0,1,0,1; req_rdy is one-hot each time.
- control_rdy held low for 5 cycles in CFG: control_val and control stay stable; XFER is entered only after the handshake.
- len 0: CFG handshake, then route_done, with no XFER cycles; fires on the output are ignored.
- TIMEOUT=4, len 5, send_rdy stuck low after 2 fires: route_err at the 4th idle cycle; busy drops and the next request is granted.
- Reset asserted mid-XFER: all outputs return to 0 asynchronously, prio_ptr returns to 0, no pulses; after release, requester 0 wins a tie.
